conv_sram_1rw1r_clr: RTL and testbench
======================================

# conv_sram_1rw1r_clr

Parametrised 1RW + 1R synchronous SRAM model with per-lane write mask, hardware clear-after-reset sequencer, and registered read-valid flags. Successor to the per-layer single-port conv buffer SRAMs in the DNNBuilder LeNet flow. Port 0 serves the layer writer (and optional readback). Port 1 lets the next layer stream reads concurrently. Behaviour is fully synthesizable-equivalent: no `#` delays and no X outputs.

## Interface
- DATA_WIDTH, 16, word width in bits; must be a multiple of WMASK_WIDTH
- ADDR_WIDTH, 9, address width
- RAM_DEPTH, 336, number of implemented words; must be ≤ 2^ADDR_WIDTH
- WMASK_WIDTH, 2, write-mask lanes; lane i covers din0[i*L +: L], where L = DATA_WIDTH/WMASK_WIDTH
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip the clear sweep
- clk0  in  1  clock; all state changes on posedge
- rst0  in  1  asynchronous, active-high reset
- csb0  in  1  port 0 active-low chip select
- web0  in  1  port 0 active-low write enable
- wmask0  in  WMASK_WIDTH  port 0 per-lane write enable, active high
- addr0  in  ADDR_WIDTH  port 0 address
- din0  in  DATA_WIDTH  port 0 write data
- dout0  out  DATA_WIDTH  port 0 read data, registered
- dvalid0  out  1  dout0 carries a new read result this cycle
- csb1  in  1  port 1 active-low chip select (read only)
- addr1  in  ADDR_WIDTH  port 1 address
- dout1  out  DATA_WIDTH  port 1 read data, registered
- dvalid1  out  1  dout1 carries a new read result this cycle
- init_busy  out  1  clear sweep in progress; all accesses are ignored
- addr_err  out  2  bit p pulses when port p accessed an address ≥ RAM_DEPTH

## Operation
- FSM states:
  - RST: while rst0 is high.
  - CLEAR: sweep counter clr_addr runs 0..RAM_DEPTH-1 and writes all-zero, one word per cycle.
  - READY: normal access.
- Transitions:
  - RST → CLEAR on the first posedge with rst0 low, when CLEAR_ON_RESET = 1.
  - RST → READY on that posedge, when CLEAR_ON_RESET = 0.
  - CLEAR → READY on the edge that writes RAM_DEPTH-1.
- Reset values: dout0 = 0, dout1 = 0, dvalid0/1 = 0, addr_err = 0, init_busy = 1, clr_addr = 0. Memory contents are not reset.
- rst0 asserting at any point (including mid-CLEAR) immediately returns to RST. The sweep restarts from address 0 afterwards.
- Port 0 write (csb0 = 0, web0 = 0, READY, addr0 < RAM_DEPTH):
  - Only lanes with wmask0[i] = 1 are updated.
  - wmask0 = 0 is a legal no-op write.
  - dout0 holds its value; dvalid0 = 0.
- Port 0 read (csb0 = 0, web0 = 1): dout0 ← mem[addr0]; dvalid0 = 1 next cycle.
- Port 1 read (csb1 = 0): dout1 ← mem[addr1]; dvalid1 = 1 next cycle.
- Idle ports: dout holds its last value, and dvalid = 0.
- Out-of-range address (≥ RAM_DEPTH, < 2^ADDR_WIDTH):
  - Writes are dropped.
  - Reads return 0 with dvalid = 1.
  - The matching addr_err bit is 1 for exactly one cycle.
- Collision (port 0 write and port 1 read of the same address in the same cycle): port 1 returns the old word (read-before-write), and the write still completes.
- While init_busy = 1: csb0/csb1 are ignored, dvalid0/1 = 0, addr_err = 0, and no user write occurs.

## Timing
- Inputs are sampled on posedge N. Read data and dvalid are valid after posedge N+1, i.e. latency 1.
- A single port sustains one access per cycle.
- A write at edge N is visible to a read sampled at edge N+1 on either port.
- CLEAR_ON_RESET = 1:
  - init_busy falls at the RAM_DEPTH-th posedge after reset release; with RAM_DEPTH = 336 that is edge 336, which also writes address 335.
  - The first accepted access is at the next edge.
- CLEAR_ON_RESET = 0: init_busy falls at the first posedge after release.
- dvalid and addr_err are single-cycle pulses per access; back-to-back reads give continuous high.
- dout values persist across idle cycles until the next read on that port.

## Test plan
- **Reset and clear:** release rst0, count cycles.
  - init_busy stays 1 for exactly 336 edges.
  - A subsequent port 1 read of every address 0..335 returns 0x0000 with dvalid1 = 1.
- **Masked write:** write 0xFFFF to addr 5 with wmask0 = 2'b11, then 0x1234 with wmask0 = 2'b01.
  - A port 0 read of addr 5 returns 0xFF34 one cycle after the read edge.
- **Collision:** mem[7] = 0xAAAA; same cycle, port 0 writes 0x5555 to addr 7 and port 1 reads addr 7.
  - dout1 = 0xAAAA.
  - A port 1 read on the next cycle gives 0x5555.
- **Out of range:** port 1 read of addr 400 → dout1 = 0, dvalid1 = 1, addr_err = 2'b10 for one cycle.
  - A port 0 write of addr 336 changes no word.
- **Reset mid-clear:** assert rst0 at clear cycle 100.
  - All outputs return to reset values asynchronously.
  - After release, the sweep restarts and init_busy lasts a full 336 cycles.
  - Accesses attempted during the sweep produce dvalid = 0.

Source files
------------

// File: rtl/conv_sram_1rw1r_clr.sv
// Dual-port conv buffer SRAM: port 0 read/write, port 1 read-only.
// Supports per-lane write masks and an optional zero-fill sweep after reset.
// Both ports have registered read data and read-valid flags.
module conv_sram_1rw1r_clr #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 9,
    parameter int RAM_DEPTH      = 336,
    parameter int WMASK_WIDTH    = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk0,
    input  logic                   rst0,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    output logic                   dvalid0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   dvalid1,
    output logic                   init_busy,
    output logic [1:0]             addr_err
);

    localparam int                    LANE_WIDTH = DATA_WIDTH / WMASK_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT  = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam bit                    DO_CLEAR   = (CLEAR_ON_RESET != 0);

    typedef enum logic [1:0] {
        ST_RST,
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

    logic ready;
    logic clear_active;
    logic clr_we;
    logic in_range0;
    logic in_range1;
    logic acc0;
    logic acc1;
    logic wr_en0;
    logic rd_en0;

    // The first edge out of RST already zeroes word 0, so edge k of the
    // sweep writes word k-1 and the last word lands on edge RAM_DEPTH.
    // rst0 gates the write so clock edges during reset leave memory alone.
    assign ready        = (state == ST_READY);
    assign clear_active = DO_CLEAR && ((state == ST_RST) || (state == ST_CLEAR));
    assign clr_we       = clear_active && !rst0;
    assign in_range0    = {1'b0, addr0} < DEPTH_EXT;
    assign in_range1    = {1'b0, addr1} < DEPTH_EXT;
    assign acc0         = ready && !csb0;
    assign acc1         = ready && !csb1;
    assign wr_en0       = acc0 && !web0 && in_range0;
    assign rd_en0       = acc0 && web0;
    assign init_busy    = !ready;

    // State register; any reset pulse drops straight back to RST.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            state <= ST_RST;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: leave the sweep on the edge that clears the last word.
    always_comb begin
        state_next = state;
        case (state)
            ST_RST:   state_next = (DO_CLEAR && (clr_addr != LAST_ADDR)) ? ST_CLEAR : ST_READY;
            ST_CLEAR: if (clr_addr == LAST_ADDR) state_next = ST_READY;
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_RST;
        endcase
    end

    // Sweep address counter; restarts at zero after every reset.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            clr_addr <= '0;
        end else if (clear_active) begin
            clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + 1'b1;
        end
    end

    // Memory array: the clear sweep or a masked port 0 write, never both.
    always_ff @(posedge clk0) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_en0) begin
            for (int i = 0; i < WMASK_WIDTH; i++) begin
                if (wmask0[i]) begin
                    mem[addr0][i*LANE_WIDTH +: LANE_WIDTH] <= din0[i*LANE_WIDTH +: LANE_WIDTH];
                end
            end
        end
    end

    // Registered read ports and status pulses.
    // Port 1 samples the pre-write word on a same-address collision.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            dout0    <= '0;
            dout1    <= '0;
            dvalid0  <= 1'b0;
            dvalid1  <= 1'b0;
            addr_err <= 2'b00;
        end else begin
            dvalid0  <= rd_en0;
            dvalid1  <= acc1;
            addr_err <= {acc1 && !in_range1, acc0 && !in_range0};
            if (rd_en0) begin
                dout0 <= in_range0 ? mem[addr0] : '0;
            end
            if (acc1) begin
                dout1 <= in_range1 ? mem[addr1] : '0;
            end
        end
    end

endmodule

// File: tb/tb_conv_sram_1rw1r_clr.sv
// Testbench for conv_sram_1rw1r_clr.
// It uses randomized and directed accesses, scored against a word-array reference model.
module tb_conv_sram_1rw1r_clr;

    localparam int DW    = 16;
    localparam int AW    = 9;
    localparam int DEPTH = 336;
    localparam int MW    = 2;

    logic          clk0 = 1'b0;
    logic          rst0 = 1'b1;
    logic          csb0 = 1'b1;
    logic          web0 = 1'b1;
    logic [MW-1:0] wmask0 = '0;
    logic [AW-1:0] addr0 = '0;
    logic [DW-1:0] din0 = '0;
    logic [DW-1:0] dout0;
    logic          dvalid0;
    logic          csb1 = 1'b1;
    logic [AW-1:0] addr1 = '0;
    logic [DW-1:0] dout1;
    logic          dvalid1;
    logic          init_busy;
    logic [1:0]    addr_err;

    typedef struct {
        int          edge_no;
        logic [15:0] d0;
        logic        v0;
        logic [15:0] d1;
        logic        v1;
        logic [1:0]  err;
        logic        busy;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_mem [DEPTH];
    int          busy_left = DEPTH;
    logic [15:0] last0 = '0;
    logic [15:0] last1 = '0;
    int          edge_cnt = 0;
    int          assert_cnt = 0;
    int          fail_cnt = 0;

    conv_sram_1rw1r_clr #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH),
        .WMASK_WIDTH(MW), .CLEAR_ON_RESET(1)
    ) dut (
        .clk0(clk0), .rst0(rst0),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(dout0), .dvalid0(dvalid0),
        .csb1(csb1), .addr1(addr1), .dout1(dout1), .dvalid1(dvalid1),
        .init_busy(init_busy), .addr_err(addr_err)
    );

    // 10-unit clock period.
    always #5 clk0 = ~clk0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of stimulus at the negedge.
    // Advance the reference model and queue what the DUT must show after the next posedge.
    task automatic applyStimulus(input logic c0, input logic w0, input logic [1:0] m0,
                                 input logic [8:0] a0, input logic [15:0] d0,
                                 input logic c1, input logic [8:0] a1);
        exp_t        e;
        logic [15:0] lm;
        @(negedge clk0);
        csb0 = c0; web0 = w0; wmask0 = m0; addr0 = a0; din0 = d0;
        csb1 = c1; addr1 = a1;
        e.edge_no = edge_cnt + 1;
        e.v0 = 1'b0;
        e.v1 = 1'b0;
        e.err = 2'b00;
        if (busy_left > 0) begin
            model_mem[DEPTH - busy_left] = 16'h0000;
            busy_left--;
        end else begin
            if (!c1) begin
                e.v1 = 1'b1;
                if (a1 < DEPTH) last1 = model_mem[a1];
                else begin
                    last1 = 16'h0000;
                    e.err[1] = 1'b1;
                end
            end
            if (!c0) begin
                if (a0 >= DEPTH) e.err[0] = 1'b1;
                if (w0) begin
                    e.v0 = 1'b1;
                    last0 = (a0 < DEPTH) ? model_mem[a0] : 16'h0000;
                end else if (a0 < DEPTH) begin
                    lm = {{8{m0[1]}}, {8{m0[0]}}};
                    model_mem[a0] = (model_mem[a0] & ~lm) | (d0 & lm);
                end
            end
        end
        e.d0 = last0;
        e.d1 = last1;
        e.busy = (busy_left > 0);
        exp_q.push_back(e);
    endtask

    function automatic logic [8:0] randAddr();
        if ($urandom_range(0, 9) == 0) return 9'($urandom_range(DEPTH, 511));
        return 9'($urandom_range(0, 15));
    endfunction

    task automatic randomOp();
        logic c0, w0, c1;
        logic [1:0] m;
        logic [8:0] a0, a1;
        logic [15:0] d;
        c0 = ($urandom_range(0, 3) == 0);
        w0 = 1'($urandom);
        m  = 2'($urandom);
        a0 = randAddr();
        a1 = randAddr();
        d  = 16'($urandom);
        c1 = ($urandom_range(0, 3) == 0);
        applyStimulus(c0, w0, m, a0, d, c1, a1);
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b1, 2'b00, 9'd0, 16'h0, 1'b1, 9'd0);
    endtask

    // Run the sweep with random access attempts.
    // Count edges until init_busy drops, bounded.
    task automatic runClear();
        int n = 0;
        bit done = 1'b0;
        for (int k = 0; k < DEPTH + 20 && !done; k++) begin
            applyStimulus(1'($urandom), 1'($urandom), 2'($urandom), 9'($urandom),
                          16'($urandom), 1'($urandom), 9'($urandom));
            @(posedge clk0);
            #2;
            if (init_busy) n++;
            else done = 1'b1;
        end
        checkOutput("clear_done", 32'(done), 32'd1);
        checkOutput("busy_edges", 32'(n + 1), 32'(DEPTH));
    endtask

    // Assert reset in the middle of a high phase and check outputs drop at once.
    task automatic asyncReset();
        @(posedge clk0);
        #3;
        rst0 = 1'b1;
        #1;
        checkOutput("rst_dout0", 32'(dout0), 32'h0);
        checkOutput("rst_dout1", 32'(dout1), 32'h0);
        checkOutput("rst_dvalid", 32'({dvalid0, dvalid1}), 32'h0);
        checkOutput("rst_addr_err", 32'(addr_err), 32'h0);
        checkOutput("rst_init_busy", 32'(init_busy), 32'h1);
        busy_left = DEPTH;
        last0 = '0;
        last1 = '0;
        repeat (2) @(posedge clk0);
        #3;
        rst0 = 1'b0;
    endtask

    // Monitor: one edge after each stimulus, pop its expectation and compare every output.
    always @(posedge clk0) begin
        exp_t e;
        edge_cnt++;
        #1;
        while (exp_q.size() > 0 && exp_q[0].edge_no < edge_cnt) void'(exp_q.pop_front());
        if (exp_q.size() > 0 && exp_q[0].edge_no == edge_cnt) begin
            e = exp_q.pop_front();
            checkOutput("dout0", 32'(dout0), 32'(e.d0));
            checkOutput("dvalid0", 32'(dvalid0), 32'(e.v0));
            checkOutput("dout1", 32'(dout1), 32'(e.d1));
            checkOutput("dvalid1", 32'(dvalid1), 32'(e.v1));
            checkOutput("addr_err", 32'(addr_err), 32'(e.err));
            checkOutput("init_busy", 32'(init_busy), 32'(e.busy));
        end
    end

    // Watchdog keeps the run bounded.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0;
        $display("[TB] starting");
        repeat (3) @(posedge clk0);
        #3;
        rst0 = 1'b0;
        runClear();

        // Every word reads back as zero after the sweep.
        for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, 1'b1, 2'b00, 9'd0, 16'h0, 1'b0, 9'(a));

        // Masked write, then read on port 0.
        applyStimulus(1'b0, 1'b0, 2'b11, 9'd5, 16'hFFFF, 1'b1, 9'd0);
        applyStimulus(1'b0, 1'b0, 2'b01, 9'd5, 16'h1234, 1'b1, 9'd0);
        applyStimulus(1'b0, 1'b1, 2'b00, 9'd5, 16'h0000, 1'b1, 9'd0);
        @(posedge clk0);
        #2;
        checkOutput("masked_read", 32'(dout0), 32'hFF34);

        // Collision: port 1 must see the old word.
        applyStimulus(1'b0, 1'b0, 2'b11, 9'd7, 16'hAAAA, 1'b1, 9'd0);
        applyStimulus(1'b0, 1'b0, 2'b11, 9'd7, 16'h5555, 1'b0, 9'd7);
        @(posedge clk0);
        #2;
        checkOutput("collision_old", 32'(dout1), 32'hAAAA);
        applyStimulus(1'b1, 1'b1, 2'b00, 9'd0, 16'h0, 1'b0, 9'd7);
        @(posedge clk0);
        #2;
        checkOutput("collision_new", 32'(dout1), 32'h5555);

        // Out-of-range port 1 read and port 0 write.
        applyStimulus(1'b1, 1'b1, 2'b00, 9'd0, 16'h0, 1'b0, 9'd400);
        @(posedge clk0);
        #2;
        checkOutput("oor_dout1", 32'(dout1), 32'h0);
        checkOutput("oor_dvalid1", 32'(dvalid1), 32'h1);
        checkOutput("oor_err", 32'(addr_err), 32'h2);
        applyStimulus(1'b0, 1'b0, 2'b11, 9'd336, 16'hBEEF, 1'b1, 9'd0);
        applyStimulus(1'b0, 1'b1, 2'b00, 9'd80, 16'h0, 1'b0, 9'd0);
        applyStimulus(1'b0, 1'b1, 2'b00, 9'd5, 16'h0, 1'b0, 9'd7);
        idle();

        // Async reset while outputs hold nonzero data.
        asyncReset();

        // Partial sweep; reset at clear cycle 100; then a full sweep.
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1'($urandom), 1'($urandom), 2'($urandom), 9'($urandom),
                          16'($urandom), 1'($urandom), 9'($urandom));
        end
        asyncReset();
        runClear();

        // Random traffic against the reference model.
        for (int k = 0; k < 2000; k++) randomOp();
        idle();
        idle();
        @(posedge clk0);
        #3;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
